io_burst_sequencer: RTL and testbench
=====================================

// Module: io_burst_sequencer
// PURPOSE
//  Sequences one N-word input burst from the host IO stream into solver memory.
//  Latches a word count and base address on start, then accepts words over a
//  valid/ready handshake and issues one registered memory write per word.
//  Tracks words remaining with an internal down counter and pulses done when the
//  count reaches zero. Sits between the IO stream port and the memory write port.
// PARAMETERS
//  DW   32  data word width (bits)
//  AW   16  memory address width; addresses wrap modulo 2^AW
//  CW   32  word-count width
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  start      in   1   begin a burst; sampled only in IDLE
//  count      in   CW  number of words in the burst; latched on accepted start
//  base_addr  in   AW  first write address; latched on accepted start
//  abort      in   1   cancel the burst in progress; honoured in XFER only
//  in_valid   in   1   stream word available
//  in_data    in   DW  stream word
//  in_ready   out  1   sequencer can take a word this cycle (combinational)
//  mem_busy   in   1   memory cannot accept a write this cycle
//  mem_we     out  1   write strobe (registered)
//  mem_addr   out  AW  write address (registered)
//  mem_wdata  out  DW  write data (registered)
//  remaining  out  CW  words still expected (counter value)
//  busy       out  1   high in LOAD and XFER
//  done       out  1   one-cycle pulse: burst completed
//  aborted    out  1   one-cycle pulse: burst cancelled by abort
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, mem_we, busy, done, aborted = 0; mem_addr,
//    mem_wdata, remaining = 0. Reset wins over every other input, mid-burst too.
//  - States: IDLE -> LOAD -> XFER -> DONE -> IDLE; XFER -> IDLE on abort.
//  - IDLE: start=1 loads the counter with count and the address register with
//    base_addr; next state LOAD. start in any other state is ignored.
//  - LOAD (1 cycle): remaining==0 -> DONE (zero-length burst, no writes);
//    otherwise -> XFER.
//  - XFER: in_ready = ~mem_busy. A beat is accepted when in_valid & in_ready.
//    On a beat: counter decrements by 1; mem_we=1, mem_addr=current address and
//    mem_wdata=in_data on the NEXT cycle (latency 1); address increments by 1
//    with wrap from 2^AW-1 to 0. A beat with remaining==1 moves state to DONE.
//    No beat: mem_we=0, counter and address hold.
//  - abort in XFER: -> IDLE next cycle, aborted=1 for that one cycle, done=0.
//    A beat accepted in the same cycle as abort is still written (mem_we next
//    cycle), then no further beats. abort and the final beat together: abort
//    wins (aborted pulses, done does not).
//  - DONE (1 cycle): done=1, busy=0, in_ready=0; -> IDLE. The write for the
//    final beat appears in this cycle.
//  - in_ready=0 in IDLE, LOAD, DONE. busy=1 in LOAD and XFER only.
//  - Counter never decrements below 0; remaining holds its value in IDLE until
//    the next accepted start.
// STRUCTURE
//  - Package io_seq_pkg: state enum (IDLE, LOAD, XFER, DONE) and 2-bit state
//    width constant; default DW/AW/CW constants.
//  - Sub-module io_word_counter: CW-bit load/decrement counter with a
//    registered zero flag; sequencer drives load on start and dec per beat.
//  - Remaining logic (FSM, address register, write-port registers) is inline.
// TESTING
//  1. count=4, base=0x0010, in_valid held 1, mem_busy=0 -> mem_we on 4
//     consecutive cycles, addr 0x10..0x13; done pulses once; remaining 4,3,2,1,0.
//  2. count=0, start -> LOAD then DONE; no mem_we; done pulses 2 cycles after start.
//  3. count=3, mem_busy high for 2 cycles after the first beat -> in_ready low,
//     no beats or writes during stall, remaining holds at 2; all 3 words land in order.
//  4. count=2, base=0xFFFF (AW=16) -> writes to 0xFFFF then 0x0000.
//  5. count=5, abort after 2 beats -> 2 writes, aborted pulse, no done, state IDLE;
//     start asserted while busy (before abort) ignored.
//  6. rst asserted mid-XFER with remaining=3 -> next cycle all outputs at reset
//     values; fresh start with count=1 completes normally.

Source files
------------

// File: rtl/io_seq_pkg.sv
// Shared types and default widths for the IO burst sequencer.
package io_seq_pkg;

  localparam int STATE_W = 2;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 16;
  localparam int DEF_CW = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/io_word_counter.sv
// Load/decrement word counter with a registered zero flag.
// It saturates at zero, so a stray decrement can never wrap it around.
module io_word_counter
  import io_seq_pkg::*;
#(
  parameter int W = DEF_CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  // Load has priority over decrement; the zero flag tracks the value being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      value <= load_value;
      zero  <= (load_value == '0);
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
      zero  <= (value == W'(1));
    end
  end

endmodule

// File: rtl/io_burst_sequencer.sv
// Moves one N-word burst from the host IO stream into solver memory,
// issuing one registered memory write per accepted stream word.
module io_burst_sequencer
  import io_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] base_addr,
  input  logic          abort,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          mem_busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [CW-1:0] remaining,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  seq_state_t    state;
  logic [AW-1:0] addr;
  logic          cnt_zero;
  logic          load_cnt;
  logic          beat;

  // Stream handshake: words flow only in XFER and only while memory can take a write.
  always_comb begin
    in_ready = (state == XFER) && !mem_busy;
    beat     = in_ready && in_valid;
    load_cnt = (state == IDLE) && start;
  end

  io_word_counter #(
    .W(CW)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (load_cnt),
    .load_value (count),
    .dec        (beat),
    .value      (remaining),
    .zero       (cnt_zero)
  );

  // Burst FSM together with the address register and the one-cycle-late write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      mem_we  <= beat;
      done    <= 1'b0;
      aborted <= 1'b0;
      if (beat) begin
        mem_addr  <= addr;
        mem_wdata <= in_data;
        addr      <= addr + AW'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr  <= base_addr;
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt_zero) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= XFER;
          end
        end
        XFER: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (beat && (remaining == CW'(1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_burst_sequencer.sv
// Directed self-checking bench for io_burst_sequencer.
module tb_io_burst_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] count;
  logic [15:0] base_addr;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mem_busy;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] remaining;
  logic        busy;
  logic        done;
  logic        aborted;

  int errors;
  int checks;

  io_burst_sequencer #(
    .DW(32),
    .AW(16),
    .CW(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .base_addr (base_addr),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_busy  (mem_busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .remaining (remaining),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; count = '0; base_addr = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; mem_busy = 1'b0;
    tick(); tick();
    checks++;
    if ({mem_we, busy, done, aborted, in_ready} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {mem_we, busy, done, aborted, in_ready});
    end
    checks++;
    if ({mem_addr, mem_wdata, remaining} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got addr=%h wdata=%h rem=%0d expected all zero", mem_addr, mem_wdata, remaining);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, done, mem_we} !== 3'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_idle: got %b expected 000", {busy, done, mem_we});
    end
  endtask

  task automatic test_basic_burst();
    logic [31:0] words [4];
    words[0] = 32'hA000_0001; words[1] = 32'hA000_0002;
    words[2] = 32'hA000_0003; words[3] = 32'hA000_0004;
    start = 1'b1; count = 32'd4; base_addr = 16'h0010; in_valid = 1'b1; in_data = words[0];
    tick();
    start = 1'b0;
    checks++;
    if ({busy, in_ready, mem_we} !== 3'b100 || remaining !== 32'd4) begin
      errors++;
      $display("[TB] FAIL basic_load: got busy/rdy/we=%b rem=%0d expected 100 rem=4", {busy, in_ready, mem_we}, remaining);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || remaining !== 32'd4 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_xfer_entry: got rdy=%b rem=%0d we=%b expected 1 4 0", in_ready, remaining, mem_we);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== (16'h0010 + 16'(i)) || mem_wdata !== words[i]) begin
        errors++;
        $display("[TB] FAIL basic_write%0d: got we=%b addr=%h data=%h expected 1 %h %h",
                 i, mem_we, mem_addr, mem_wdata, 16'h0010 + 16'(i), words[i]);
      end
      checks++;
      if (remaining !== 32'(3 - i) || done !== (i == 3) || busy !== (i != 3)) begin
        errors++;
        $display("[TB] FAIL basic_status%0d: got rem=%0d done=%b busy=%b expected %0d %b %b",
                 i, remaining, done, busy, 3 - i, (i == 3), (i != 3));
      end
      if (i < 3) in_data = words[i + 1];
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if ({done, mem_we, busy} !== 3'b000 || remaining !== 32'd0) begin
      errors++;
      $display("[TB] FAIL basic_after: got done/we/busy=%b rem=%0d expected 000 0", {done, mem_we, busy}, remaining);
    end
  endtask

  task automatic test_zero_length();
    start = 1'b1; count = 32'd0; base_addr = 16'h0030; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, mem_we, in_ready} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL zero_load: got busy/done/we/rdy=%b expected 1000", {busy, done, mem_we, in_ready});
    end
    tick();
    checks++;
    if ({busy, done, mem_we, in_ready} !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL zero_done: got busy/done/we/rdy=%b expected 0100", {busy, done, mem_we, in_ready});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({busy, done, mem_we} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL zero_idle: got busy/done/we=%b expected 000", {busy, done, mem_we});
    end
  endtask

  task automatic test_stall();
    start = 1'b1; count = 32'd3; base_addr = 16'h0020; in_valid = 1'b1; in_data = 32'hB000_0000;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0020 || mem_wdata !== 32'hB000_0000 || remaining !== 32'd2) begin
      errors++;
      $display("[TB] FAIL stall_first: got we=%b addr=%h data=%h rem=%0d expected 1 0020 b0000000 2",
               mem_we, mem_addr, mem_wdata, remaining);
    end
    mem_busy = 1'b1; in_data = 32'hB000_0001;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (mem_we !== 1'b0 || remaining !== 32'd2 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got we=%b rem=%0d busy=%b expected 0 2 1", i, mem_we, remaining, busy);
      end
    end
    mem_busy = 1'b0;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0021 || mem_wdata !== 32'hB000_0001 || remaining !== 32'd1) begin
      errors++;
      $display("[TB] FAIL stall_second: got we=%b addr=%h data=%h rem=%0d expected 1 0021 b0000001 1",
               mem_we, mem_addr, mem_wdata, remaining);
    end
    in_data = 32'hB000_0002;
    tick();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0022 || mem_wdata !== 32'hB000_0002 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_third: got we=%b addr=%h data=%h done=%b expected 1 0022 b0000002 1",
               mem_we, mem_addr, mem_wdata, done);
    end
    tick();
  endtask

  task automatic test_wrap();
    start = 1'b1; count = 32'd2; base_addr = 16'hFFFF; in_valid = 1'b1; in_data = 32'hC000_0000;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'hFFFF || mem_wdata !== 32'hC000_0000) begin
      errors++;
      $display("[TB] FAIL wrap_first: got we=%b addr=%h data=%h expected 1 ffff c0000000", mem_we, mem_addr, mem_wdata);
    end
    in_data = 32'hC000_0001;
    tick();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0000 || mem_wdata !== 32'hC000_0001 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_second: got we=%b addr=%h data=%h done=%b expected 1 0000 c0000001 1",
               mem_we, mem_addr, mem_wdata, done);
    end
    tick();
  endtask

  task automatic test_abort();
    start = 1'b1; count = 32'd5; base_addr = 16'h0040; in_valid = 1'b1; in_data = 32'hD000_0000;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; count = 32'd9; base_addr = 16'h0099; in_data = 32'hD000_0001;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0041 || remaining !== 32'd3) begin
      errors++;
      $display("[TB] FAIL abort_start_ignored: got we=%b addr=%h rem=%0d expected 1 0041 3", mem_we, mem_addr, remaining);
    end
    start = 1'b0; in_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({aborted, done, busy, mem_we} !== 4'b1000 || remaining !== 32'd3) begin
      errors++;
      $display("[TB] FAIL abort_pulse: got aborted/done/busy/we=%b rem=%0d expected 1000 3",
               {aborted, done, busy, mem_we}, remaining);
    end
    tick();
    checks++;
    if ({aborted, done, busy, mem_we} !== 4'b0000 || remaining !== 32'd3) begin
      errors++;
      $display("[TB] FAIL abort_idle: got aborted/done/busy/we=%b rem=%0d expected 0000 3",
               {aborted, done, busy, mem_we}, remaining);
    end
    // Abort coinciding with the final beat: the beat is written, abort wins over done.
    start = 1'b1; count = 32'd1; base_addr = 16'h0050;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1; abort = 1'b1; in_data = 32'hD000_0050;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    checks++;
    if ({mem_we, aborted, done, busy} !== 4'b1100 || mem_addr !== 16'h0050 || mem_wdata !== 32'hD000_0050) begin
      errors++;
      $display("[TB] FAIL abort_final_beat: got we/aborted/done/busy=%b addr=%h data=%h expected 1100 0050 d0000050",
               {mem_we, aborted, done, busy}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_we, aborted, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_final_after: got we/aborted/done=%b expected 000", {mem_we, aborted, done});
    end
  endtask

  task automatic test_reset_mid_burst();
    start = 1'b1; count = 32'd5; base_addr = 16'h0060; in_valid = 1'b1; in_data = 32'hE000_0000;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (remaining !== 32'd3 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_setup: got rem=%0d busy=%b expected 3 1", remaining, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({mem_we, busy, done, aborted, in_ready} !== 5'b0 || {mem_addr, mem_wdata, remaining} !== 80'h0) begin
      errors++;
      $display("[TB] FAIL midrst_values: got flags=%b addr=%h data=%h rem=%0d expected all zero",
               {mem_we, busy, done, aborted, in_ready}, mem_addr, mem_wdata, remaining);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    start = 1'b1; count = 32'd1; base_addr = 16'h0070;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1; in_data = 32'hE000_0070;
    tick();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0070 || mem_wdata !== 32'hE000_0070 || done !== 1'b1 || remaining !== 32'd0) begin
      errors++;
      $display("[TB] FAIL midrst_fresh: got we=%b addr=%h data=%h done=%b rem=%0d expected 1 0070 e0000070 1 0",
               mem_we, mem_addr, mem_wdata, done, remaining);
    end
    tick();
  endtask

  // Scenario sequence and summary.
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_burst();
    test_zero_length();
    test_stall();
    test_wrap();
    test_abort();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
